// File: rtl/tl_pkg.sv
// Shared receive-side TL types: beat stream, packet class, and the Fmt/Type classifier.
package tl_pkg;

    localparam int TL_STREAM_W = 128;

    typedef struct packed {
        logic [TL_STREAM_W-1:0] data;
        logic                   sop;
        logic                   eop;
    } tl_stream_t;

    typedef enum logic [1:0] {
        POSTED = 2'd0,
        NP     = 2'd1,
        CPL    = 2'd2,
        DROP   = 2'd3
    } tl_class_e;

    localparam int FMT_MSB  = 31;
    localparam int FMT_LSB  = 29;
    localparam int TYPE_MSB = 28;
    localparam int TYPE_LSB = 24;

    localparam logic [4:0] TYPE_MWR    = 5'b00000;
    localparam logic [4:0] TYPE_IO     = 5'b00010;
    localparam logic [1:0] TYPE_MSG_HI = 2'b10;
    localparam logic [3:0] TYPE_MRD_HI = 4'b0000;
    localparam logic [3:0] TYPE_CFG_HI = 4'b0010;
    localparam logic [3:0] TYPE_CPL_HI = 4'b0101;

    // fmt[2] set means a TLP prefix, which this receiver does not support.
    function automatic tl_class_e tl_classify(input logic [2:0] fmt, input logic [4:0] typ);
        tl_class_e cls;
        cls = DROP;
        if (fmt[2])
            cls = DROP;
        else if (fmt[1] && typ == TYPE_MWR)
            cls = POSTED;
        else if (fmt[0] && typ[4:3] == TYPE_MSG_HI)
            cls = POSTED;
        else if (!fmt[1] && typ[4:1] == TYPE_MRD_HI)
            cls = NP;
        else if (!fmt[0] && typ == TYPE_IO)
            cls = NP;
        else if (!fmt[0] && typ[4:1] == TYPE_CFG_HI)
            cls = NP;
        else if (!fmt[0] && typ[4:1] == TYPE_CPL_HI)
            cls = CPL;
        return cls;
    endfunction

endpackage

// File: rtl/tl_rx_stage.sv
// Single-entry valid/ready register feeding one receive queue.
// Latency: 1 cycle from load to out_vld.
// Backpressure: in_rdy = !out_vld || out_rdy, so a full stage reloads on the cycle it drains.
module tl_rx_stage
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    output logic       in_rdy,
    input  tl_stream_t in_dat,
    output logic       out_vld,
    input  logic       out_rdy,
    output tl_stream_t out_dat
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/tl_rx_demux.sv
// Steers received TLPs into posted / non-posted / completion queues; drops and counts the rest.
// Latency: 1 cycle through a registered stage per class; TL_RX_DEMUX_STATS_EN adds per-class packet counters.
// Backpressure: input stalls only when the stage of the class being routed is full and not draining.
module tl_rx_demux
    import tl_pkg::*;
#(
    parameter int STREAM_W = TL_STREAM_W
) (
    input  logic        clk,
    input  logic        rst,
    input  tl_stream_t  tl_rx_i,
    input  logic        tl_rx_valid_i,
    output logic        tl_rx_ready_o,
    output tl_stream_t  pkt_posted_o,
    output logic        pkt_posted_valid_o,
    input  logic        pkt_posted_ready_i,
    output tl_stream_t  pkt_np_o,
    output logic        pkt_np_valid_o,
    input  logic        pkt_np_ready_i,
    output tl_stream_t  pkt_cpl_o,
    output logic        pkt_cpl_valid_o,
    input  logic        pkt_cpl_ready_i,
`ifdef TL_RX_DEMUX_STATS_EN
    output logic [31:0] posted_cnt_o,
    output logic [31:0] np_cnt_o,
    output logic [31:0] cpl_cnt_o,
`endif
    output logic [15:0] drop_cnt_o,
    output logic [15:0] frame_err_cnt_o
);

    if (STREAM_W != TL_STREAM_W || STREAM_W < 32) begin : g_bad_stream_w
        $error("tl_rx_demux: STREAM_W must match tl_pkg::TL_STREAM_W and be >= 32");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_e;

    state_e     state_q, state_d;
    tl_class_e  route_q, route_d;
    tl_class_e  dec_cls, beat_cls;
    logic [2:0] stg_in_vld, stg_rdy;
    logic       acc, frame_err_inc, drop_inc;

    assign dec_cls = tl_classify(tl_rx_i.data[FMT_MSB:FMT_LSB], tl_rx_i.data[TYPE_MSB:TYPE_LSB]);

    // A sop always reclassifies; a non-sop beat follows the latched route or is discarded.
    always_comb begin
        beat_cls = DROP;
        if (tl_rx_i.sop)
            beat_cls = dec_cls;
        else if (state_q == ST_FWD)
            beat_cls = route_q;
    end

    always_comb begin
        tl_rx_ready_o = 1'b1;
        case (beat_cls)
            POSTED:  tl_rx_ready_o = stg_rdy[0];
            NP:      tl_rx_ready_o = stg_rdy[1];
            CPL:     tl_rx_ready_o = stg_rdy[2];
            default: tl_rx_ready_o = 1'b1;
        endcase
    end

    assign acc           = tl_rx_valid_i && tl_rx_ready_o;
    assign stg_in_vld[0] = tl_rx_valid_i && (beat_cls == POSTED);
    assign stg_in_vld[1] = tl_rx_valid_i && (beat_cls == NP);
    assign stg_in_vld[2] = tl_rx_valid_i && (beat_cls == CPL);

    // Framing error: sop inside a packet, or a continuation beat with no packet open.
    assign frame_err_inc = acc && (tl_rx_i.sop != (state_q == ST_IDLE));
    assign drop_inc      = acc && tl_rx_i.sop && (dec_cls == DROP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            route_q <= POSTED;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (acc) begin
            if (tl_rx_i.sop) begin
                route_d = dec_cls;
                if (tl_rx_i.eop)
                    state_d = ST_IDLE;
                else
                    state_d = (dec_cls == DROP) ? ST_DROP : ST_FWD;
            end else if (tl_rx_i.eop) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_o      <= '0;
            frame_err_cnt_o <= '0;
        end else begin
            if (drop_inc && drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;
            if (frame_err_inc && frame_err_cnt_o != 16'hFFFF)
                frame_err_cnt_o <= frame_err_cnt_o + 16'd1;
        end
    end

`ifdef TL_RX_DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            posted_cnt_o <= '0;
            np_cnt_o     <= '0;
            cpl_cnt_o    <= '0;
        end else if (acc && tl_rx_i.sop) begin
            case (dec_cls)
                POSTED:  posted_cnt_o <= posted_cnt_o + 32'd1;
                NP:      np_cnt_o     <= np_cnt_o + 32'd1;
                CPL:     cpl_cnt_o    <= cpl_cnt_o + 32'd1;
                default: ;
            endcase
        end
    end
`endif

    tl_rx_stage u_stage_posted (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (stg_in_vld[0]),
        .in_rdy  (stg_rdy[0]),
        .in_dat  (tl_rx_i),
        .out_vld (pkt_posted_valid_o),
        .out_rdy (pkt_posted_ready_i),
        .out_dat (pkt_posted_o)
    );

    tl_rx_stage u_stage_np (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (stg_in_vld[1]),
        .in_rdy  (stg_rdy[1]),
        .in_dat  (tl_rx_i),
        .out_vld (pkt_np_valid_o),
        .out_rdy (pkt_np_ready_i),
        .out_dat (pkt_np_o)
    );

    tl_rx_stage u_stage_cpl (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (stg_in_vld[2]),
        .in_rdy  (stg_rdy[2]),
        .in_dat  (tl_rx_i),
        .out_vld (pkt_cpl_valid_o),
        .out_rdy (pkt_cpl_ready_i),
        .out_dat (pkt_cpl_o)
    );

endmodule

// File: tb/tb_tl_rx_demux.sv
// Self-checking bench for tl_rx_demux: directed sequences, a classification table and a randomized run.
module tb_tl_rx_demux;
    import tl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    tl_stream_t  rx;
    logic        rx_vld, rx_rdy;
    tl_stream_t  p_dat, n_dat, c_dat;
    logic        p_vld, n_vld, c_vld;
    logic [2:0]  ordy;
    logic [15:0] drop_cnt, ferr_cnt;
`ifdef TL_RX_DEMUX_STATS_EN
    logic [31:0] p_cnt, n_cnt, c_cnt;
`endif

    tl_rx_demux dut (
        .clk                (clk),
        .rst                (rst),
        .tl_rx_i            (rx),
        .tl_rx_valid_i      (rx_vld),
        .tl_rx_ready_o      (rx_rdy),
        .pkt_posted_o       (p_dat),
        .pkt_posted_valid_o (p_vld),
        .pkt_posted_ready_i (ordy[0]),
        .pkt_np_o           (n_dat),
        .pkt_np_valid_o     (n_vld),
        .pkt_np_ready_i     (ordy[1]),
        .pkt_cpl_o          (c_dat),
        .pkt_cpl_valid_o    (c_vld),
        .pkt_cpl_ready_i    (ordy[2]),
`ifdef TL_RX_DEMUX_STATS_EN
        .posted_cnt_o       (p_cnt),
        .np_cnt_o           (n_cnt),
        .cpl_cnt_o          (c_cnt),
`endif
        .drop_cnt_o         (drop_cnt),
        .frame_err_cnt_o    (ferr_cnt)
    );

    logic [2:0] out_vld;
    tl_stream_t out_dat [3];
    assign out_vld    = {c_vld, n_vld, p_vld};
    assign out_dat[0] = p_dat;
    assign out_dat[1] = n_dat;
    assign out_dat[2] = c_dat;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-class queue of accepted-but-undelivered beats, packet-open flag, counters.
    tl_stream_t q [3][$];
    bit         m_in_pkt;
    int         m_route;
    int         m_drop, m_ferr;
    int         m_stat [3];

    typedef struct {
        logic [2:0] fmt;
        logic [4:0] typ;
        logic [2:0] vld;
    } vec_t;
    vec_t tbl [18];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_class(input logic [2:0] fmt, input logic [4:0] typ);
        casez ({fmt, typ})
            8'b01?_00000, 8'b0?1_10???:              return 0;
            8'b00?_0000?, 8'b0?0_00010, 8'b0?0_0010?: return 1;
            8'b0?0_0101?:                             return 2;
            default:                                  return 3;
        endcase
    endfunction

    function automatic tl_stream_t mk(input logic [2:0] fmt, input logic [4:0] typ,
                                      input logic sop, input logic eop);
        tl_stream_t b;
        b.data = {$urandom, $urandom, $urandom, fmt, typ, 24'($urandom)};
        b.sop  = sop;
        b.eop  = eop;
        return b;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            m_stat[k] = 0;
        end
        m_in_pkt = 1'b0;
        m_route  = 3;
        m_drop   = 0;
        m_ferr   = 0;
    endtask

    // One clock: drive, check ready before the edge, advance model, check outputs after the edge.
    task automatic cycle(input logic r, input logic v, input tl_stream_t b,
                         input logic [2:0] rd, output logic acc);
        int   c;
        logic er;
        rst    = r;
        rx_vld = v;
        rx     = b;
        ordy   = rd;
        #1;
        c = 3;
        if (b.sop)
            c = ref_class(b.data[31:29], b.data[28:24]);
        else if (m_in_pkt)
            c = m_route;
        if (c == 3)
            er = 1'b1;
        else
            er = (q[c].size() == 0) || rd[c];
        if (!r)
            check("rx_ready", rx_rdy, er);
        acc = !r && v && er;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            for (int k = 0; k < 3; k++)
                if (q[k].size() != 0 && rd[k])
                    void'(q[k].pop_front());
            if (acc) begin
                if (b.sop) begin
                    if (m_in_pkt)
                        m_ferr = sat16(m_ferr + 1);
                    if (c == 3)
                        m_drop = sat16(m_drop + 1);
                    else
                        m_stat[c]++;
                    m_in_pkt = !b.eop;
                    m_route  = c;
                end else if (!m_in_pkt) begin
                    m_ferr = sat16(m_ferr + 1);
                end else if (b.eop) begin
                    m_in_pkt = 1'b0;
                end
                if (c != 3)
                    q[c].push_back(b);
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out_vld[%0d]", k), out_vld[k], q[k].size() != 0);
            if (q[k].size() != 0)
                check($sformatf("out_dat[%0d]", k), out_dat[k], q[k][0]);
        end
        check("drop_cnt", drop_cnt, m_drop);
        check("frame_err_cnt", ferr_cnt, m_ferr);
`ifdef TL_RX_DEMUX_STATS_EN
        check("posted_cnt", p_cnt, m_stat[0]);
        check("np_cnt", n_cnt, m_stat[1]);
        check("cpl_cnt", c_cnt, m_stat[2]);
`endif
    endtask

    task automatic send_beat(input tl_stream_t b, input logic [2:0] rd);
        logic acc;
        int   n;
        n = 0;
        do begin
            cycle(1'b0, 1'b1, b, rd, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted after %0d cycles, acceptance required", n);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, '0, 3'b111, acc);
    endtask

    task automatic do_reset();
        logic acc;
        cycle(1'b1, 1'b0, '0, 3'b111, acc);
        cycle(1'b1, 1'b0, '0, 3'b111, acc);
    endtask

    initial begin
        tl_stream_t b1, b2, b3, b4;
        logic       acc, g_in, v, sop, eop;
        logic [2:0] rd, fmt;
        logic [4:0] typ;
        int         k, exp_drop;

        tbl[0]  = '{3'b010, 5'b00000, 3'b001};
        tbl[1]  = '{3'b011, 5'b00000, 3'b001};
        tbl[2]  = '{3'b001, 5'b10000, 3'b001};
        tbl[3]  = '{3'b011, 5'b10101, 3'b001};
        tbl[4]  = '{3'b000, 5'b00000, 3'b010};
        tbl[5]  = '{3'b001, 5'b00001, 3'b010};
        tbl[6]  = '{3'b000, 5'b00010, 3'b010};
        tbl[7]  = '{3'b010, 5'b00010, 3'b010};
        tbl[8]  = '{3'b000, 5'b00100, 3'b010};
        tbl[9]  = '{3'b010, 5'b00101, 3'b010};
        tbl[10] = '{3'b000, 5'b01010, 3'b100};
        tbl[11] = '{3'b010, 5'b01011, 3'b100};
        tbl[12] = '{3'b001, 5'b00010, 3'b000};
        tbl[13] = '{3'b100, 5'b00000, 3'b000};
        tbl[14] = '{3'b010, 5'b11111, 3'b000};
        tbl[15] = '{3'b000, 5'b10000, 3'b000};
        tbl[16] = '{3'b011, 5'b01010, 3'b000};
        tbl[17] = '{3'b010, 5'b00001, 3'b000};

        rst = 1'b1; rx_vld = 1'b0; rx = '0; ordy = 3'b111;
        model_clear();
        do_reset();

        // Reset state
        rst = 1'b0; rx_vld = 1'b0; rx = '0; ordy = 3'b111;
        #1;
        check("rst_ready", rx_rdy, 1'b1);
        check("rst_vld", out_vld, 3'b000);
        check("rst_p_dat", p_dat, '0);
        check("rst_n_dat", n_dat, '0);
        check("rst_c_dat", c_dat, '0);
        check("rst_drop", drop_cnt, 16'd0);
        check("rst_ferr", ferr_cnt, 16'd0);

        // MWr, 3 beats, back-to-back on posted
        b1 = mk(3'b010, 5'b00000, 1'b1, 1'b0);
        b2 = mk(3'b010, 5'b00000, 1'b0, 1'b0);
        b3 = mk(3'b010, 5'b00000, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, b1, 3'b111, acc);
        check("mwr_acc1", acc, 1'b1);
        check("mwr_b1", {out_vld, p_dat}, {3'b001, b1});
        cycle(1'b0, 1'b1, b2, 3'b111, acc);
        check("mwr_b2", {out_vld, p_dat}, {3'b001, b2});
        cycle(1'b0, 1'b1, b3, 3'b111, acc);
        check("mwr_b3", {out_vld, p_dat}, {3'b001, b3});
        idle(1);

        // MRd single beat, then CplD 2 beats
        b1 = mk(3'b000, 5'b00000, 1'b1, 1'b1);
        send_beat(b1, 3'b111);
        check("mrd_np", {out_vld, n_dat}, {3'b010, b1});
        b2 = mk(3'b010, 5'b01010, 1'b1, 1'b0);
        b3 = mk(3'b010, 5'b01010, 1'b0, 1'b1);
        send_beat(b2, 3'b111);
        check("cpld_b1", {out_vld, c_dat}, {3'b100, b2});
        send_beat(b3, 3'b111);
        check("cpld_b2", {out_vld, c_dat}, {3'b100, b3});
        idle(1);

        // CplD with completion ready held low for 5 cycles
        b1 = mk(3'b010, 5'b01010, 1'b1, 1'b0);
        b2 = mk(3'b010, 5'b01010, 1'b0, 1'b1);
        send_beat(b1, 3'b111);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, b2, 3'b011, acc);
            check("stall_acc", acc, 1'b0);
            check("stall_hold", {c_vld, c_dat}, {1'b1, b1});
        end
        send_beat(b2, 3'b111);
        check("stall_release", {c_vld, c_dat}, {1'b1, b2});
        idle(1);

        // Unsupported Type 11111, 4 beats, all dropped
        for (int i = 0; i < 4; i++) begin
            send_beat(mk(3'b010, 5'b11111, i == 0, i == 3), 3'b111);
            check("drop_novld", out_vld, 3'b000);
        end
        check("drop_cnt_1", drop_cnt, 16'd1);

        // Orphan beat in IDLE, then sop arriving mid-MWr
        do_reset();
        send_beat(mk(3'b010, 5'b00000, 1'b0, 1'b0), 3'b111);
        send_beat(mk(3'b010, 5'b00000, 1'b1, 1'b0), 3'b111);
        send_beat(mk(3'b010, 5'b00000, 1'b0, 1'b0), 3'b111);
        b4 = mk(3'b000, 5'b00000, 1'b1, 1'b1);
        send_beat(b4, 3'b111);
        check("ferr_2", ferr_cnt, 16'd2);
        check("ferr_reroute", {n_vld, n_dat}, {1'b1, b4});
        idle(1);

        // Reset during beat 2 of 4
        do_reset();
        send_beat(mk(3'b010, 5'b00000, 1'b1, 1'b0), 3'b111);
        cycle(1'b1, 1'b1, mk(3'b010, 5'b00000, 1'b0, 1'b0), 3'b000, acc);
        check("midrst_vld", out_vld, 3'b000);
        check("midrst_dat", p_dat, '0);
        send_beat(mk(3'b010, 5'b00000, 1'b0, 1'b0), 3'b111);
        send_beat(mk(3'b010, 5'b00000, 1'b0, 1'b1), 3'b111);
        check("midrst_ferr", ferr_cnt, 16'd2);
        check("midrst_novld", out_vld, 3'b000);
`ifdef TL_RX_DEMUX_STATS_EN
        check("midrst_stats", {p_cnt, n_cnt, c_cnt}, 96'd0);
`endif

        // Classification table, single-beat packets
        do_reset();
        exp_drop = 0;
        for (int i = 0; i < 18; i++) begin
            send_beat(mk(tbl[i].fmt, tbl[i].typ, 1'b1, 1'b1), 3'b111);
            if (tbl[i].vld == 3'b000)
                exp_drop++;
            check($sformatf("class_vld[%0d]", i), out_vld, tbl[i].vld);
            check($sformatf("class_drop[%0d]", i), drop_cnt, exp_drop);
        end
        idle(1);

        // Randomized traffic against the model
        g_in = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            sop = g_in ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 19) != 0);
            eop = ($urandom_range(0, 2) == 0);
            k   = $urandom_range(0, 21);
            if (k < 18) begin
                fmt = tbl[k].fmt;
                typ = tbl[k].typ;
            end else begin
                fmt = 3'($urandom);
                typ = 5'($urandom);
            end
            rd = 3'($urandom) | 3'($urandom);
            cycle(1'b0, v, mk(fmt, typ, sop, eop), rd, acc);
            if (acc)
                g_in = sop ? !eop : (g_in && !eop);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_rx_demux.md
# tl_rx_demux

Receive-side transaction-layer demultiplexer. Accepts the TLP beat stream delivered by the DLL, decodes Fmt/Type from the header DW0 on the start-of-packet beat, and steers the whole packet into the posted, non-posted or completion receive queue. Unsupported or malformed packets are discarded and counted. Each output has a one-beat registered stage, so the block mirrors the transmit arbiter on the opposite side of the TL.

## Interface
Parameters:
- STREAM_W, 128: beat data width in bits; must be ≥ 32.

Ports (clk and rst first):
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- tl_rx_i, in, tl_pkg::tl_stream_t: beat from the DLL, with fields data[STREAM_W-1:0], sop, eop.
- tl_rx_valid_i, in, 1: beat valid.
- tl_rx_ready_o, out, 1: beat accepted when valid && ready.
- pkt_posted_o, out, tl_stream_t: posted queue beat.
- pkt_posted_valid_o / pkt_posted_ready_i, out/in, 1 each: posted handshake.
- pkt_np_o, out, tl_stream_t: non-posted queue beat.
- pkt_np_valid_o / pkt_np_ready_i, out/in, 1 each: non-posted handshake.
- pkt_cpl_o, out, tl_stream_t: completion queue beat.
- pkt_cpl_valid_o / pkt_cpl_ready_i, out/in, 1 each: completion handshake.
- drop_cnt_o, out, 16: saturating count of dropped packets.
- frame_err_cnt_o, out, 16: saturating count of framing errors.

## Operation
- DW0 is data[31:0]. Fmt = data[31:29]. Type = data[28:24].
- Classification on an accepted sop beat:
  - POSTED: Fmt 01x with Type 00000 (MWr); Fmt 0x1 with Type 10xxx (Msg/MsgD).
  - NP: Fmt 00x with Type 0000x (MRd/MRdLk); Fmt 0x0 with Type 00010 (IO); Fmt 0x0 with Type 0010x (Cfg).
  - CPL: Fmt 0x0 with Type 0101x (Cpl/CplD/CplLk).
  - Any other value, including Fmt 1xx (prefix): DROP.
- FSM states:
  - IDLE: waiting for sop.
  - FWD: class is latched in a 2-bit route register.
  - DROP: discarding the rest of the packet.
- Transitions:
  - IDLE, accepted sop: the class decoded from that beat selects FWD or DROP. An sop+eop beat forwards or drops that beat and stays in IDLE.
  - IDLE, accepted non-sop beat: the beat is discarded, frame_err_cnt increments, state stays IDLE.
  - FWD or DROP, accepted eop: return to IDLE.
  - FWD or DROP, accepted sop: frame_err_cnt increments and the beat is reclassified as a new packet. The aborted packet is not given a synthetic eop.
- Each output stage is a single register. It loads when it is selected and (!valid || ready). It clears valid on ready when it is not reloaded.
- tl_rx_ready_o:
  - DROP, or a beat being discarded: 1.
  - Otherwise: the load condition of the selected stage. On a sop beat the selected stage is the decoded class.
  - The path from stream to class to ready is combinational. There is no dependency on tl_rx_valid_i.
- drop_cnt increments once per dropped packet, on its sop beat. Both counters saturate at 0xFFFF.

## Timing
- Latency is 1 cycle from input acceptance to output valid. Full throughput of 1 beat/cycle is sustained when the downstream ready is held high.
- Beats are never duplicated, lost (except in DROP or discard), or reordered within a class.
- Output valid stays asserted and data stays stable until ready.
- Reset values:
  - All *_valid_o are 0.
  - Output data is 0.
  - State is IDLE.
  - Both counters are 0.
  - tl_rx_ready_o is 1 while in IDLE with empty stages.
- Reset asserted mid-packet: the packet is abandoned. The next accepted beat must carry sop, otherwise it is counted as a framing error.
- A stall on one class blocks the input only while a packet of that class is being routed to it. Other classes' stages still drain.

## Configuration
- TL_RX_DEMUX_STATS_EN defined: adds the outputs posted_cnt_o, np_cnt_o and cpl_cnt_o, each 32 bits. They are wrapping counters of forwarded packets, incremented on the accepted sop beat, and reset to 0.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Structure
- tl_pkg holds:
  - tl_stream_t.
  - A tl_class_e enum: POSTED, NP, CPL, DROP.
  - Fmt/Type localparams.
  - A function tl_classify(fmt, type) returning tl_class_e.
- The three output registers are instances of one sub-module, tl_rx_stage: a single-entry valid/ready register.

## Test plan
- MWr (Fmt 010, Type 00000), 3 beats with all readies high: the beats appear on posted one cycle later, back-to-back; np and cpl stay idle.
- MRd (Fmt 000) single beat with sop and eop, then CplD (Fmt 010, Type 01010), 2 beats: one np beat, then two cpl beats, each with 1-cycle latency.
- A CplD packet with pkt_cpl_ready_i held low for 5 cycles: tl_rx_ready_o is 0 after the stage fills, data holds stable, and there is no beat loss after release.
- Type 11111 packet of 4 beats: all beats accepted with ready=1, no output valid, drop_cnt_o = 1.
- Non-sop beat in IDLE, then sop arriving mid-MWr: frame_err_cnt_o = 2 and the new packet is routed by its own header.
- Reset asserted during beat 2 of 4: outputs clear next cycle. Beats 3–4 with no sop after reset give frame_err_cnt_o = 2. With STATS_EN defined, counters read 0.
